// File: rtl/config_sram_loader.sv
// config_sram_loader
// Feeds the config_sram_data serial shifter: takes one {address,data} word at
// a time from a valid/ready source, shifts it out MSB-first, lets the shifter
// settle for one cycle, then pulses config_set to commit the word.
// Every output except in_ready is a flop loaded from the next-state logic.

module config_sram_loader #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 16
) (
  input  logic                 cclk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_BITS-1:0] in_addr,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 shift_enable,
  output logic                 shift_in,
  output logic                 config_set,
  output logic                 busy,
  output logic                 write_done,
  output logic [CNT_BITS-1:0]  write_count
);

  localparam int N       = ADDR_BITS + DATA_BITS;
  localparam int BC_BITS = (N > 1) ? $clog2(N) : 1;
  localparam logic [BC_BITS-1:0] LAST_BIT = BC_BITS'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
    SET,
    RECOVER
  } state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         shreg_q, shreg_d;
  logic [BC_BITS-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 shift_enable_d;
  logic                 shift_in_d;
  logic                 config_set_d;
  logic                 busy_d;
  logic                 write_done_d;
  logic [CNT_BITS-1:0]  write_count_d;

  // Ready is only meaningful in IDLE; gating with rst_n keeps it low while
  // reset is being applied so no word is handshaken during reset.
  assign in_ready = (state_q == IDLE) && rst_n;

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      shift_enable <= 1'b0;
      shift_in     <= 1'b0;
      config_set   <= 1'b0;
      busy         <= 1'b0;
      write_done   <= 1'b0;
      write_count  <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_enable <= shift_enable_d;
      shift_in     <= shift_in_d;
      config_set   <= config_set_d;
      busy         <= busy_d;
      write_done   <= write_done_d;
      write_count  <= write_count_d;
    end
  end

  // Next-state and next-output logic. The output flops are loaded with the
  // values for the state being entered, so each state's outputs appear in the
  // cycle that state occupies. The shift register is pre-loaded with the word
  // and its MSB is driven out on entry to SHIFT; each later SHIFT cycle shifts
  // left and presents the following bit.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    shift_enable_d = 1'b0;
    shift_in_d     = 1'b0;
    config_set_d   = 1'b0;
    write_done_d   = 1'b0;
    write_count_d  = write_count;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d        = {in_addr, in_data};
          bit_cnt_d      = '0;
          shift_enable_d = 1'b1;
          shift_in_d     = in_addr[ADDR_BITS-1];
          state_d        = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          shreg_d   = '0;
          state_d   = GAP;
        end else begin
          bit_cnt_d      = bit_cnt_q + BC_BITS'(1);
          shreg_d        = shreg_q << 1;
          shift_enable_d = 1'b1;
          shift_in_d     = shreg_q[N-2];
        end
      end

      GAP: begin
        config_set_d = 1'b1;
        state_d      = SET;
      end

      SET: begin
        write_done_d  = 1'b1;
        write_count_d = write_count + CNT_BITS'(1);
        state_d       = RECOVER;
      end

      RECOVER: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
